// File: rtl/instr_stim_if.sv
// Handshake and fetch bus between the instruction stimulus sequencer (master)
// and the execution unit / instruction memory side (slave).
interface instr_stim_if #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 12
);
    logic                  stall;
    logic [ADDR_WIDTH-1:0] PC_value;
    logic                  fetch_mode;
    logic                  ifu_rd_req;
    logic [ADDR_WIDTH-1:0] ifu_rd_addr;
    logic [DATA_WIDTH-1:0] ifu_rd_data;
    logic                  instr_valid;
    logic [DATA_WIDTH-1:0] instr_word;

    modport master (
        input  stall, PC_value, fetch_mode, ifu_rd_data,
        output ifu_rd_req, ifu_rd_addr, instr_valid, instr_word
    );

    modport slave (
        output stall, PC_value, fetch_mode, ifu_rd_data,
        input  ifu_rd_req, ifu_rd_addr, instr_valid, instr_word
    );
endinterface

// File: rtl/instr_stim_gen.sv
// Instruction stimulus sequencer: preamble (CLA CLL, NOP), then NUM_INSTR words from
// an LFSR or from memory at PC, then done. Define INSTR_STIM_IOT_FILTER_EN to turn random IOTs into NOPs.
module instr_stim_gen #(
    parameter int              DATA_WIDTH = 12,
    parameter int              ADDR_WIDTH = 12,
    parameter int              NUM_INSTR  = 1000000,
    parameter logic [15:0]     LFSR_SEED  = 16'hACE1,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = ADDR_WIDTH'(12'o200)
) (
    input  logic                               clk,
    input  logic                               reset,
    instr_stim_if.master                       bus,
    output logic [ADDR_WIDTH-1:0]              base_addr,
    output logic [$clog2(NUM_INSTR+1)-1:0]     issued_count,
    output logic                               done
);
    localparam int                    CNT_W        = $clog2(NUM_INSTR + 1);
    localparam logic [CNT_W-1:0]      CNT_LAST     = CNT_W'(NUM_INSTR);
    localparam logic [DATA_WIDTH-1:0] WORD_CLA_CLL = DATA_WIDTH'(12'o7300);
    localparam logic [DATA_WIDTH-1:0] WORD_NOP     = DATA_WIDTH'(12'o7000);
    localparam logic [15:0]           LFSR_MASK    = 16'hB400;

    typedef enum logic [2:0] {
        S_WAIT_RDY,
        S_PRE0,
        S_PRE1,
        S_DISPATCH,
        S_FETCH,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] instr_word_q, instr_word_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  rand_q, rand_d;

    logic                  instr_valid;
    logic                  rd_req;
    logic                  accept;
    logic                  last_issue;
    logic [15:0]           lfsr_step;
    logic [DATA_WIDTH-1:0] rand_word;

    assign accept     = instr_valid && !bus.stall;
    assign last_issue = (count_q + CNT_W'(1)) == CNT_LAST;
    assign lfsr_step  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);

    always_comb begin
        rand_word = DATA_WIDTH'(lfsr_q);
`ifdef INSTR_STIM_IOT_FILTER_EN
        // IOT opcodes would hit unmodelled peripherals, so they become NOPs.
        if (lfsr_q[11:9] == 3'b110) begin
            rand_word = WORD_NOP;
        end
`endif
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_WAIT_RDY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT_RDY: if (!bus.stall) state_d = S_PRE0;
            S_PRE0:     if (accept)     state_d = S_PRE1;
            S_PRE1:     if (accept)     state_d = S_DISPATCH;
            S_DISPATCH: state_d = bus.fetch_mode ? S_FETCH : S_PRESENT;
            S_FETCH:    state_d = S_PRESENT;
            S_PRESENT: begin
                if (accept) begin
                    state_d = last_issue ? S_DONE : S_DISPATCH;
                end
            end
            S_DONE:     state_d = S_DONE;
            default:    state_d = S_WAIT_RDY;
        endcase
    end

    // Output logic
    always_comb begin
        instr_valid = 1'b0;
        rd_req      = 1'b0;
        done        = 1'b0;
        case (state_q)
            S_PRE0, S_PRE1, S_PRESENT: instr_valid = 1'b1;
            S_DISPATCH:                rd_req      = bus.fetch_mode;
            S_DONE:                    done        = 1'b1;
            default: ;
        endcase
    end

    assign bus.instr_valid  = instr_valid;
    assign bus.instr_word   = instr_word_q;
    assign bus.ifu_rd_req   = rd_req;
    assign bus.ifu_rd_addr  = rd_req ? bus.PC_value : '0;
    assign base_addr        = START_ADDR;
    assign issued_count     = count_q;

    // Datapath next values; the word only changes while instr_valid is low.
    always_comb begin
        instr_word_d = instr_word_q;
        lfsr_d       = lfsr_q;
        count_d      = count_q;
        rand_d       = rand_q;
        case (state_q)
            S_WAIT_RDY: begin
                if (!bus.stall) instr_word_d = WORD_CLA_CLL;
            end
            S_PRE0: begin
                if (accept) instr_word_d = WORD_NOP;
            end
            S_DISPATCH: begin
                rand_d = !bus.fetch_mode;
                if (!bus.fetch_mode) instr_word_d = rand_word;
            end
            S_FETCH: begin
                instr_word_d = bus.ifu_rd_data;
            end
            S_PRESENT: begin
                if (accept) begin
                    if (count_q != CNT_LAST) count_d = count_q + CNT_W'(1);
                    if (rand_q)              lfsr_d  = lfsr_step;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_word_q <= '0;
            lfsr_q       <= LFSR_SEED;
            count_q      <= '0;
            rand_q       <= 1'b0;
        end else begin
            instr_word_q <= instr_word_d;
            lfsr_q       <= lfsr_d;
            count_q      <= count_d;
            rand_q       <= rand_d;
        end
    end
endmodule

// File: tb/tb_instr_stim_gen.sv
// Self-checking bench for instr_stim_gen (NUM_INSTR=4): preamble, random and fetched
// words, stalls, reset mid-run, done. Expected IOT filtering follows INSTR_STIM_IOT_FILTER_EN.
module tb_instr_stim_gen;
    localparam int DW = 12;
    localparam int AW = 12;
    localparam int NI = 4;
    localparam int CW = $clog2(NI + 1);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_stim_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
    logic [AW-1:0] base_addr;
    logic [CW-1:0] issued_count;
    logic          done;

    instr_stim_gen #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_INSTR(NI),
        .LFSR_SEED(16'hACE1), .START_ADDR(12'o200)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .base_addr(base_addr), .issued_count(issued_count), .done(done)
    );

    typedef struct {
        logic        fm;
        logic [11:0] pc;
        int          stall_n;
        logic [11:0] exp_word;
    } vec_t;

    vec_t        tab[4];
    logic [11:0] lfsr_lo[4];
    logic [11:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          req_cnt;
    int          exp_cnt;
    logic [11:0] exp_addr;
    logic        pend;
    logic [11:0] paddr;

    function automatic logic [11:0] mem_word(input logic [11:0] a);
        return (a == 12'o0200) ? 12'o1234 : (a ^ 12'o5555);
    endfunction

    function automatic logic [11:0] filt(input logic [11:0] w);
`ifdef INSTR_STIM_IOT_FILTER_EN
        if (w[11:9] == 3'b110) return 12'o7000;
`endif
        return w;
    endfunction

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: observe fetch strobe and acceptance, drive memory data after the edge.
    task automatic advance();
        logic [11:0] w;
        #1;
        if (bus.ifu_rd_req) begin
            req_cnt++;
            check_eq("rd_addr", 32'(bus.ifu_rd_addr), 32'(exp_addr));
            pend  = 1'b1;
            paddr = bus.ifu_rd_addr;
        end
        if (bus.instr_valid && !bus.stall) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_accept: got word 0x%0h, required no acceptance", bus.instr_word);
            end else begin
                w = exp_q.pop_front();
                check_eq("accepted_word", 32'(bus.instr_word), 32'(w));
                $display("accept word %04o (expected %04o) count %0d", bus.instr_word, w, issued_count);
            end
        end
        @(posedge clk);
        #1;
        bus.ifu_rd_data = pend ? mem_word(paddr) : 12'o7777;
        pend = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset_vals();
        check_eq("rst_valid", 32'(bus.instr_valid), 0);
        check_eq("rst_word",  32'(bus.instr_word), 0);
        check_eq("rst_rd_req", 32'(bus.ifu_rd_req), 0);
        check_eq("rst_rd_addr", 32'(bus.ifu_rd_addr), 0);
        check_eq("rst_count", 32'(issued_count), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("base_addr", 32'(base_addr), 32'(12'o200));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_reset_vals();
        @(negedge clk); #1;
        @(negedge clk); #1;
        exp_q.delete();
        exp_cnt = 0;
        reset = 1'b0;
    endtask

    task automatic do_preamble();
        advance();
        check_eq("pre0_valid", 32'(bus.instr_valid), 1);
        check_eq("pre0_word", 32'(bus.instr_word), 32'(12'o7300));
        exp_q.push_back(12'o7300);
        advance();
        check_eq("pre1_valid", 32'(bus.instr_valid), 1);
        check_eq("pre1_word", 32'(bus.instr_word), 32'(12'o7000));
        exp_q.push_back(12'o7000);
        advance();
        check_eq("dispatch_gap_valid", 32'(bus.instr_valid), 0);
    endtask

    task automatic run_instr(input logic fm, input logic [11:0] pc, input int stall_n,
                             input logic [11:0] exp_word);
        int          waitc;
        logic [11:0] held;
        logic [CW-1:0] cnt0;
        bus.fetch_mode = fm;
        bus.PC_value   = pc;
        bus.stall      = 1'b0;
        exp_addr       = pc;
        req_cnt        = 0;
        exp_q.push_back(exp_word);
        waitc = 0;
        while (!bus.instr_valid && waitc < 10) begin
            advance();
            waitc++;
        end
        check_eq("present_latency", 32'(waitc), fm ? 2 : 1);
        if (stall_n > 0) begin
            held = bus.instr_word;
            cnt0 = issued_count;
            bus.stall      = 1'b1;
            bus.fetch_mode = ~fm;
            for (int i = 0; i < stall_n; i++) begin
                advance();
                check_eq("stall_valid", 32'(bus.instr_valid), 1);
                check_eq("stall_word", 32'(bus.instr_word), 32'(held));
                check_eq("stall_count", 32'(issued_count), 32'(cnt0));
            end
            bus.stall      = 1'b0;
            bus.fetch_mode = fm;
        end
        advance();
        exp_cnt++;
        check_eq("issued_count", 32'(issued_count), 32'(exp_cnt));
        check_eq("rd_req_pulses", 32'(req_cnt), fm ? 1 : 0);
    endtask

    task automatic check_done();
        check_eq("done_rise", 32'(done), 1);
        check_eq("done_valid", 32'(bus.instr_valid), 0);
        check_eq("done_count", 32'(issued_count), NI);
        for (int i = 0; i < 3; i++) begin
            advance();
            check_eq("done_sticky", 32'(done), 1);
            check_eq("done_no_valid", 32'(bus.instr_valid), 0);
            check_eq("done_count_sat", 32'(issued_count), NI);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

    initial begin
        // Low 12 bits of LFSR states 0..3 from seed 16'hACE1 (mask 16'hB400).
        lfsr_lo[0] = 12'hCE1;
        lfsr_lo[1] = 12'h270;
        lfsr_lo[2] = 12'h138;
        lfsr_lo[3] = 12'h89C;
        tab[0] = '{1'b0, 12'o0000, 7, filt(12'hCE1)};
        tab[1] = '{1'b1, 12'o0200, 0, 12'o1234};
        tab[2] = '{1'b0, 12'o0000, 0, filt(12'h270)};
        tab[3] = '{1'b1, 12'o0377, 3, mem_word(12'o0377)};

        reset           = 1'b1;
        bus.stall       = 1'b1;
        bus.fetch_mode  = 1'b0;
        bus.PC_value    = '0;
        bus.ifu_rd_data = '0;
        pend            = 1'b0;
        paddr           = '0;
        exp_addr        = '0;
        req_cnt         = 0;
        exp_cnt         = 0;
        @(negedge clk); #1;

        // Reset release with stall held, then four random words.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            advance();
            check_eq("stalled_no_valid", 32'(bus.instr_valid), 0);
        end
        bus.stall = 1'b0;
        do_preamble();
        for (int i = 0; i < NI; i++) run_instr(1'b0, 12'o0, 0, filt(lfsr_lo[i]));
        check_done();

        // Table: stall in PRESENT, fetched words, LFSR untouched by fetches.
        bus.stall = 1'b0;
        do_reset();
        do_preamble();
        for (int i = 0; i < 4; i++) run_instr(tab[i].fm, tab[i].pc, tab[i].stall_n, tab[i].exp_word);
        check_done();

        // Reset while presenting the fourth word.
        bus.stall = 1'b0;
        do_reset();
        do_preamble();
        for (int i = 0; i < 3; i++) run_instr(1'b0, 12'o0, 0, filt(lfsr_lo[i]));
        bus.fetch_mode = 1'b0;
        advance();
        check_eq("midrun_present_valid", 32'(bus.instr_valid), 1);
        check_eq("midrun_count", 32'(issued_count), 3);
        do_reset();
        do_preamble();
        for (int i = 0; i < NI; i++) run_instr(1'b0, 12'o0, 0, filt(lfsr_lo[i]));
        check_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_stim_gen.md
# instr_stim_gen

Parametrised, synthesizable instruction stimulus sequencer that feeds the execution unit in unit-level and FPGA bring-up benches, replacing a free-running behavioural opcode driver.

- After reset it issues a fixed preamble (CLA CLL, then NOP).
- It then issues `NUM_INSTR` instructions, one per stall-gated handshake.
- Each instruction comes either from an internal LFSR or from memory at the current PC, selected per instruction.
- It then raises `done`.

## Interface
Parameters:
- `DATA_WIDTH`, 12, instruction word width.
- `ADDR_WIDTH`, 12, address width.
- `NUM_INSTR`, 1000000, instructions issued after the preamble; must be ≥1.
- `LFSR_SEED`, 16'hACE1, nonzero LFSR reset value.
- `START_ADDR`, 12'o200, value driven on `base_addr`.

Ports:
- `clk` input 1: clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `stall` input 1: execution unit busy; while high, the presented word is held and not consumed.
- `PC_value` input `ADDR_WIDTH`: current PC from the execution unit.
- `fetch_mode` input 1: 0 = random word, 1 = fetch from memory at `PC_value`; sampled when a RUN instruction begins.
- `ifu_rd_req` output 1: memory read strobe, one cycle wide.
- `ifu_rd_addr` output `ADDR_WIDTH`: read address.
- `ifu_rd_data` input `DATA_WIDTH`: read data, valid the cycle after `ifu_rd_req`.
- `base_addr` output `ADDR_WIDTH`: constant `START_ADDR`.
- `instr_valid` output 1: `instr_word` is being presented.
- `instr_word` output `DATA_WIDTH`: instruction word.
- `issued_count` output `$clog2(NUM_INSTR+1)`: RUN instructions accepted so far.
- `done` output 1: all instructions issued; sticky until reset.

## Operation
Handshake:
- A word is accepted on any rising edge where `instr_valid && !stall`.
- `instr_word` is stable from the cycle `instr_valid` rises until acceptance.

States:
- **WAIT_RDY** (reset state): `instr_valid`=0. Move to PRE0 on the first cycle `stall`==0.
- **PRE0**: present 12'o7300 (CLA CLL). On accept, go to PRE1.
- **PRE1**: present 12'o7000 (NOP). On accept, go to DISPATCH.
- **DISPATCH**: sample `fetch_mode`.
  - 0: load the low `DATA_WIDTH` bits of the LFSR into `instr_word`; go to PRESENT.
  - 1: pulse `ifu_rd_req`, drive `ifu_rd_addr`=`PC_value`; go to FETCH.
- **FETCH**: capture `ifu_rd_data` into `instr_word`; go to PRESENT.
- **PRESENT**: `instr_valid`=1. On accept:
  - increment `issued_count`;
  - if the word was random, advance the LFSR;
  - if the new count equals `NUM_INSTR`, go to DONE; otherwise go to DISPATCH.
- **DONE**: `instr_valid`=0, `done`=1. Terminal until reset.

LFSR:
- 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400).
- Shifts right: if the LSB is 1, XOR the mask after the shift.
- Advances only on acceptance of a random word; it never advances in the preamble or on fetched words.

Boundaries:
- `stall` high in PRESENT: hold indefinitely; no count, no LFSR step.
- `fetch_mode` changes while in PRESENT or FETCH: ignored until the next DISPATCH.
- `issued_count` saturates at `NUM_INSTR`; it never wraps.

Reset:
- Any-time assertion returns to WAIT_RDY immediately.
- LFSR reloads `LFSR_SEED`; count is cleared.

## Timing
Reset values:
- `instr_valid`=0, `instr_word`=0, `ifu_rd_req`=0, `ifu_rd_addr`=0, `issued_count`=0, `done`=0.
- `base_addr`=`START_ADDR` at all times.

Latency with `stall`=0:
- Random instruction: DISPATCH→PRESENT = 2 cycles per instruction.
- Fetched instruction: DISPATCH→FETCH→PRESENT = 3 cycles.
- `ifu_rd_req` is high for exactly one cycle per fetch.

After reset release, the first `instr_valid` rises one cycle after the first cycle with `stall`==0.

`done` rises on the edge after the final acceptance.

## Configuration
Macro `INSTR_STIM_IOT_FILTER_EN`:
- **Defined:** a random word whose bits [11:9]==3'b110 (IOT) is replaced by 12'o7000 (NOP) before presentation.
  - The replacement is still counted.
  - The LFSR advances normally.
  - Fetched words are never filtered.
- **Undefined:** random words are presented unmodified.

## Test plan
- **Reset release with stall held:** hold `stall`=1 for 5 cycles after `reset` falls, then drop it. Required: no `instr_valid` while stalled; then 12'o7300, then 12'o7000, one cycle each.
- **Random sequence:** `NUM_INSTR`=4, seed 16'hACE1, `fetch_mode`=0, `stall`=0. Required:
  - the 4 accepted words equal the low 12 bits of LFSR states 0–3;
  - `issued_count` reaches 4;
  - `done`=1 one cycle after the last acceptance;
  - no further `instr_valid`.
- **Stall in PRESENT:** raise `stall` for 7 cycles during PRESENT. Required: `instr_word` is unchanged; `issued_count` and the LFSR are frozen; one acceptance after `stall` drops.
- **Fetch mode:** `fetch_mode`=1, `PC_value`=12'o0200, memory returns 12'o1234. Required: `ifu_rd_req` pulses once with `ifu_rd_addr`=12'o0200; `instr_word`=12'o1234 is presented 2 cycles later; the LFSR does not advance.
- **Reset mid-run:** assert `reset` in PRESENT after 3 issues. Required: all outputs return to reset values the same cycle; after release the preamble repeats and the first random word equals LFSR state 0.
- **Filter on:** with `INSTR_STIM_IOT_FILTER_EN` defined and the seed chosen so the first word has bits [11:9]=3'b110. Required: 12'o7000 is presented and counted; the next word is LFSR state 1.
